alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer that computes unsigned 32x32 multiply (64-bit product) and unsigned 32/32 divide (quotient + remainder) using the existing 32-bit ALU as its only adder/subtractor.
- Drives the ALU operand and command inputs once per cycle and registers the result; sits between the core issue logic and the ALU instance.
- Uses a valid/ready request channel and a valid/ready response channel; one operation is in flight at a time.

---
 rtl/alu_muldiv_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// ============================================================================
// Module   : alu_muldiv_seq
// Purpose  : Multi-cycle unsigned 32x32 multiply / 32/32 divide sequencer
//            that reuses an external 32-bit ALU as its only adder.
//            Optional macro MULDIV_ZERO_BYPASS_EN: zero-operand early finish.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv_seq #(
    parameter logic [2:0] CMD_ADD = 3'b000,
    parameter logic [2:0] CMD_SUB = 3'b001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_lo,
    output logic [31:0] resp_hi,
    output logic        resp_divzero,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [2:0]  alu_command,
    input  logic [31:0] alu_result,
    input  logic        alu_carryout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_count;
    logic [31:0] r_hi;      // product high half / partial remainder
    logic [31:0] r_lo;      // multiplier shift reg / dividend-quotient shift reg
    logic [31:0] r_mcand;   // multiplicand / divisor
    logic [31:0] r_resp_lo;
    logic [31:0] r_resp_hi;
    logic        r_resp_divzero;

    logic        w_accept;
    logic        w_divzero;
    logic        w_bypass;
    logic        w_last;
    logic [31:0] w_shifted;
    logic        w_ge;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;

    assign req_ready    = (r_state == S_IDLE);
    assign resp_valid   = (r_state == S_DONE);
    assign resp_lo      = r_resp_lo;
    assign resp_hi      = r_resp_hi;
    assign resp_divzero = r_resp_divzero;

    assign w_accept  = req_valid && (r_state == S_IDLE);
    assign w_divzero = req_op && (req_b == 32'd0);
    assign w_last    = (r_count == 5'd31);
    assign w_shifted = {r_hi[30:0], r_lo[31]};
    // Bit shifted out of rem[31] means the partial remainder already exceeds any divisor
    assign w_ge      = r_hi[31] | alu_carryout;

`ifdef MULDIV_ZERO_BYPASS_EN
    assign w_bypass = req_op ? ((req_a == 32'd0) && (req_b != 32'd0))
                             : ((req_a == 32'd0) || (req_b == 32'd0));
`else
    assign w_bypass = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        alu_operandA = 32'd0;
        alu_operandB = 32'd0;
        alu_command  = CMD_ADD;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_divzero || w_bypass) w_state_nxt = S_DONE;
                    else if (req_op)           w_state_nxt = S_DIV;
                    else                       w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                alu_operandA = r_hi;
                alu_operandB = r_lo[0] ? r_mcand : 32'd0;
                alu_command  = CMD_ADD;
                w_hi_nxt     = {alu_carryout, alu_result[31:1]};
                w_lo_nxt     = {alu_result[0], r_lo[31:1]};
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DIV: begin
                alu_operandA = w_shifted;
                alu_operandB = r_mcand;
                alu_command  = CMD_SUB;
                w_hi_nxt     = w_ge ? alu_result : w_shifted;
                w_lo_nxt     = {r_lo[30:0], w_ge};
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (resp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count        <= 5'd0;
            r_hi           <= 32'd0;
            r_lo           <= 32'd0;
            r_mcand        <= 32'd0;
            r_resp_lo      <= 32'd0;
            r_resp_hi      <= 32'd0;
            r_resp_divzero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_count <= 5'd0;
                        r_hi    <= 32'd0;
                        r_lo    <= req_a;
                        r_mcand <= req_b;
                        if (w_divzero) begin
                            r_resp_lo      <= 32'hFFFF_FFFF;
                            r_resp_hi      <= req_a;
                            r_resp_divzero <= 1'b1;
                        end else if (w_bypass) begin
                            r_resp_lo      <= 32'd0;
                            r_resp_hi      <= 32'd0;
                            r_resp_divzero <= 1'b0;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    r_count <= r_count + 5'd1;
                    r_hi    <= w_hi_nxt;
                    r_lo    <= w_lo_nxt;
                    if (w_last) begin
                        r_resp_lo      <= w_lo_nxt;
                        r_resp_hi      <= w_hi_nxt;
                        r_resp_divzero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
// ============================================================================
// Module   : tb_alu_muldiv_seq
// Purpose  : Directed self-checking bench for alu_muldiv_seq with an ALU model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_muldiv_seq;

    localparam logic [2:0] C_ADD = 3'b000;
    localparam logic [2:0] C_SUB = 3'b001;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_lo;
    logic [31:0] resp_hi;
    logic        resp_divzero;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [2:0]  alu_command;
    logic [31:0] alu_result;
    logic        alu_carryout;

    int tests;
    int fails;
    int sub_seen;

    alu_muldiv_seq #(.CMD_ADD(C_ADD), .CMD_SUB(C_SUB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_lo      (resp_lo),
        .resp_hi      (resp_hi),
        .resp_divzero (resp_divzero),
        .alu_operandA (alu_operandA),
        .alu_operandB (alu_operandB),
        .alu_command  (alu_command),
        .alu_result   (alu_result),
        .alu_carryout (alu_carryout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: carryout on SUB is the no-borrow flag (A + ~B + 1)
    always_comb begin
        if (alu_command == C_SUB)
            {alu_carryout, alu_result} = {1'b0, alu_operandA} + {1'b0, ~alu_operandB} + 33'd1;
        else
            {alu_carryout, alu_result} = {1'b0, alu_operandA} + {1'b0, alu_operandB};
    end

    always @(posedge clk) if (alu_command == C_SUB) sub_seen++;

    // Issue one request from IDLE (#1 after an edge); returns when resp_valid seen
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int rdy_hi);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; rdy_hi = 0;
        while (!resp_valid && lat < 200) begin
            if (req_ready) rdy_hi++;
            @(posedge clk); #1;
            lat++;
        end
        if (req_ready) rdy_hi++;
    endtask

    task automatic test_reset();
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        tests++; if ({resp_hi, resp_lo} !== 64'd0) begin fails++; $display("FAIL reset_resp got %h want 0", {resp_hi, resp_lo}); end
        tests++; if (resp_divzero !== 1'b0) begin fails++; $display("FAIL reset_divzero got %b want 0", resp_divzero); end
        tests++; if ({alu_operandA, alu_operandB, alu_command} !== {64'd0, C_ADD}) begin
            fails++; $display("FAIL reset_alu got %h/%h/%b want 0/0/000", alu_operandA, alu_operandB, alu_command); end
    endtask

    task automatic test_mul_basic();
        int lat, rh;
        resp_ready = 1'b1;
        run_op(1'b0, 32'd7, 32'd6, lat, rh);
        tests++; if (lat !== 32) begin fails++; $display("FAIL mul7x6_latency got %0d want 32", lat); end
        tests++; if (rh !== 0) begin fails++; $display("FAIL mul7x6_req_ready_busy got %0d high cycles want 0", rh); end
        tests++; if ({resp_hi, resp_lo, resp_divzero} !== {32'd0, 32'd42, 1'b0}) begin
            fails++; $display("FAIL mul7x6_result got %h_%h dz=%b want 0_2a dz=0", resp_hi, resp_lo, resp_divzero); end
        @(posedge clk); #1;
        tests++; if ({resp_valid, req_ready} !== 2'b01) begin
            fails++; $display("FAIL mul7x6_handshake got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_mul_max();
        int lat, rh;
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, rh);
        tests++; if ({resp_hi, resp_lo} !== 64'hFFFF_FFFE_0000_0001) begin
            fails++; $display("FAIL mul_max got %h_%h want fffffffe_00000001", resp_hi, resp_lo); end
        @(posedge clk); #1;
    endtask

    task automatic test_div();
        int lat, rh;
        run_op(1'b1, 32'd100, 32'd7, lat, rh);
        tests++; if (lat !== 32) begin fails++; $display("FAIL div100_7_latency got %0d want 32", lat); end
        tests++; if ({resp_hi, resp_lo, resp_divzero} !== {32'd2, 32'd14, 1'b0}) begin
            fails++; $display("FAIL div100_7 got rem=%0d quo=%0d dz=%b want 2/14/0", resp_hi, resp_lo, resp_divzero); end
        @(posedge clk); #1;
        run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, lat, rh);
        tests++; if ({resp_hi, resp_lo} !== {32'h7FFF_FFFE, 32'd1}) begin
            fails++; $display("FAIL div_bigrem got rem=%h quo=%h want 7ffffffe/1", resp_hi, resp_lo); end
        @(posedge clk); #1;
    endtask

    task automatic test_divzero();
        int lat, rh;
        sub_seen = 0;
        run_op(1'b1, 32'd5, 32'd0, lat, rh);
        tests++; if (lat !== 0) begin fails++; $display("FAIL divzero_latency got %0d want 0", lat); end
        tests++; if ({resp_hi, resp_lo, resp_divzero} !== {32'd5, 32'hFFFF_FFFF, 1'b1}) begin
            fails++; $display("FAIL divzero_result got %h_%h dz=%b want 5_ffffffff dz=1", resp_hi, resp_lo, resp_divzero); end
        @(posedge clk); #1;
        tests++; if (sub_seen !== 0) begin fails++; $display("FAIL divzero_no_sub got %0d SUB cycles want 0", sub_seen); end
    endtask

    task automatic test_stall();
        int lat, rh;
        logic ok;
        resp_ready = 1'b0;
        run_op(1'b0, 32'd3, 32'd5, lat, rh);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_op = 1'b1; req_a = 32'd77; req_b = 32'd0;
            @(posedge clk); #1;
            if (!(resp_valid && resp_lo == 32'd15 && resp_hi == 32'd0 && !req_ready)) ok = 1'b0;
        end
        tests++; if (ok !== 1'b1) begin
            fails++; $display("FAIL stall_hold got valid=%b lo=%0d hi=%0d want 1/15/0", resp_valid, resp_lo, resp_hi); end
        // Request presented in the handshake cycle must not be taken
        req_op = 1'b0; req_a = 32'd2; req_b = 32'd2; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests++; if ({resp_valid, req_ready, resp_lo} !== {2'b01, 32'd15}) begin
            fails++; $display("FAIL stall_release got valid=%b ready=%b lo=%0d want 0/1/15", resp_valid, req_ready, resp_lo); end
        run_op(1'b0, 32'd2, 32'd2, lat, rh);
        tests++; if ({resp_hi, resp_lo} !== {32'd0, 32'd4}) begin
            fails++; $display("FAIL mul2x2 got %h_%h want 0_4", resp_hi, resp_lo); end
        @(posedge clk); #1;
    endtask

    task automatic test_bypass();
        int lat, rh, exp_lat;
`ifdef MULDIV_ZERO_BYPASS_EN
        exp_lat = 0;
`else
        exp_lat = 32;
`endif
        run_op(1'b0, 32'd0, 32'd9, lat, rh);
        tests++; if (lat !== exp_lat) begin fails++; $display("FAIL mul0x9_latency got %0d want %0d", lat, exp_lat); end
        tests++; if ({resp_hi, resp_lo} !== 64'd0) begin fails++; $display("FAIL mul0x9 got %h_%h want 0_0", resp_hi, resp_lo); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, rh;
        req_op = 1'b1; req_a = 32'd1000; req_b = 32'd3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
        #2 reset_n = 1'b0;
        #1;
        tests++; if ({req_ready, resp_valid, resp_divzero, resp_lo, resp_hi, alu_operandA, alu_operandB, alu_command}
                     !== {1'b1, 2'b00, 128'd0, C_ADD}) begin
            fails++; $display("FAIL reset_mid got ready=%b valid=%b alu=%h/%h/%b resp=%h_%h want 1/0/0/0/000/0",
                              req_ready, resp_valid, alu_operandA, alu_operandB, alu_command, resp_hi, resp_lo); end
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        tests++; if ({req_ready, resp_valid} !== 2'b10) begin
            fails++; $display("FAIL reset_mid_release got ready=%b valid=%b want 1/0", req_ready, resp_valid); end
        run_op(1'b1, 32'd9, 32'd3, lat, rh);
        tests++; if ({resp_hi, resp_lo} !== {32'd0, 32'd3}) begin
            fails++; $display("FAIL div9_3 got rem=%0d quo=%0d want 0/3", resp_hi, resp_lo); end
        @(posedge clk); #1;
    endtask

    initial begin
        tests = 0; fails = 0; sub_seen = 0;
        reset_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_a = 32'd0; req_b = 32'd0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_mul_basic();
        test_mul_max();
        test_div();
        test_divzero();
        test_stall();
        test_bypass();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
